// File: rtl/data_memory_responder.sv
// Data-port responder for the single-cycle datapath: word RAM plus an I/O page with
// a cycle counter, a valid/ready transmit FIFO, a status word and a dropped-write counter.
module data_memory_responder #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_DEPTH     = 256,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  input  logic                     MemWrite,
  output logic [DATA_WIDTH-1:0]    ReadData,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [ADDRESS_WIDTH-1:0] CycleAddr  = ADDRESS_WIDTH'(32'hFFFF_0000);
  localparam logic [ADDRESS_WIDTH-1:0] TxAddr     = ADDRESS_WIDTH'(32'hFFFF_0004);
  localparam logic [ADDRESS_WIDTH-1:0] StatusAddr = ADDRESS_WIDTH'(32'hFFFF_0008);
  localparam logic [ADDRESS_WIDTH-1:0] DropAddr   = ADDRESS_WIDTH'(32'hFFFF_000C);

  logic [DATA_WIDTH-1:0] r_mem  [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_cycle;
  logic [DATA_WIDTH-1:0] r_drop;
  logic                  r_err;

  logic            w_hit_ram, w_hit_cycle, w_hit_tx, w_hit_status, w_hit_drop, w_mapped;
  logic            w_aligned, w_wr_ok, w_err_evt;
  logic            w_full, w_empty, w_pop, w_push_req, w_push, w_drop_evt, w_drop_clr;
  logic [IdxW-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_status;

  // Low two address bits are ignored for decoding; they only matter for write alignment.
  assign w_idx        = Address[IdxW+1:2];
  assign w_hit_ram    = (Address[ADDRESS_WIDTH-1:IdxW+2] == '0);
  assign w_hit_cycle  = (Address[ADDRESS_WIDTH-1:2] == CycleAddr[ADDRESS_WIDTH-1:2]);
  assign w_hit_tx     = (Address[ADDRESS_WIDTH-1:2] == TxAddr[ADDRESS_WIDTH-1:2]);
  assign w_hit_status = (Address[ADDRESS_WIDTH-1:2] == StatusAddr[ADDRESS_WIDTH-1:2]);
  assign w_hit_drop   = (Address[ADDRESS_WIDTH-1:2] == DropAddr[ADDRESS_WIDTH-1:2]);
  assign w_mapped     = w_hit_ram | w_hit_cycle | w_hit_tx | w_hit_status | w_hit_drop;

  assign w_aligned  = (Address[1:0] == 2'b00);
  assign w_wr_ok    = MemWrite & w_aligned & w_mapped;
  assign w_err_evt  = MemWrite & (~w_aligned | ~w_mapped);

  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & out_ready;
  assign w_push_req = w_wr_ok & w_hit_tx;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop_evt = w_push_req & w_full & ~w_pop;
  assign w_drop_clr = w_wr_ok & w_hit_drop;

  assign out_valid = ~w_empty;
  assign out_data  = r_fifo[r_rd_ptr];
  assign err       = r_err;

  always_comb begin
    w_status      = '0;
    w_status[4:2] = 3'(r_count);
    w_status[1]   = w_empty;
    w_status[0]   = w_full;
  end

  always_comb begin
    ReadData = '0;
    if (w_hit_ram)         ReadData = r_mem[w_idx];
    else if (w_hit_cycle)  ReadData = r_cycle;
    else if (w_hit_status) ReadData = w_status;
    else if (w_hit_drop)   ReadData = r_drop;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++)  r_mem[i]  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cycle  <= '0;
      r_drop   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + DATA_WIDTH'(1);
      if (w_wr_ok && w_hit_ram) r_mem[w_idx] <= WriteData;
      if (w_push) begin
        r_fifo[r_wr_ptr] <= WriteData;
        r_wr_ptr         <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (w_drop_clr)                     r_drop <= '0;
      else if (w_drop_evt && ~&r_drop)    r_drop <= r_drop + DATA_WIDTH'(1);
      if (w_err_evt) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: inputs change on the falling edge,
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_data_memory_responder;

  localparam logic [31:0] CycleA  = 32'hFFFF_0000;
  localparam logic [31:0] TxA     = 32'hFFFF_0004;
  localparam logic [31:0] StatusA = 32'hFFFF_0008;
  localparam logic [31:0] DropA   = 32'hFFFF_000C;

  logic        CLK, rst, MemWrite, out_ready, out_valid, err;
  logic [31:0] Address, WriteData, ReadData, out_data;
  int          n_checks, n_errors;

  data_memory_responder dut (
    .CLK       (CLK),
    .rst       (rst),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    #1;
    data = ReadData;
  endtask

  // Holds the write across exactly one rising edge, returning on the next falling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(negedge CLK);
    MemWrite  = 1'b0;
    #1;
  endtask

  logic [31:0] v;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    MemWrite  = 1'b0;
    out_ready = 1'b0;
    Address   = '0;
    WriteData = '0;
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    #1;

    // Reset state and counter start
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    rd(StatusA, v); check("rst_status", v, 32'h2);
    rd(CycleA, v);  check("cycle_first", v, 32'd0);
    repeat (100) @(negedge CLK);
    rd(CycleA, v);  check("cycle_100", v, 32'd100);

    // RAM write/read, including same-cycle old value
    Address = 32'h10; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
    #1; check("ram_same_cycle", ReadData, 32'h0);
    @(negedge CLK); MemWrite = 1'b0;
    rd(32'h10, v); check("ram_rd_10", v, 32'hDEAD_BEEF);
    rd(32'h13, v); check("ram_rd_13", v, 32'hDEAD_BEEF);
    check("err_clean", {31'b0, err}, 32'h0);

    // Misaligned and unmapped writes
    wr(32'h12, 32'h11);
    rd(32'h10, v); check("misalign_ram", v, 32'hDEAD_BEEF);
    check("misalign_err", {31'b0, err}, 32'h1);
    wr(32'h8000_0000, 32'h55);
    rd(32'h8000_0000, v); check("unmapped_rd", v, 32'h0);
    check("unmapped_err", {31'b0, err}, 32'h1);
    rd(TxA, v); check("tx_rd_zero", v, 32'h0);

    // Counter wrap via deposit
    @(negedge CLK);
    dut.r_cycle = 32'hFFFF_FFFF;
    rd(CycleA, v); check("cycle_max", v, 32'hFFFF_FFFF);
    @(negedge CLK);
    rd(CycleA, v); check("cycle_wrap", v, 32'h0);

    // FIFO fill with sink stalled
    wr(TxA, 32'd1);
    check("push_valid", {31'b0, out_valid}, 32'h1);
    check("push_head", out_data, 32'd1);
    rd(StatusA, v); check("status_1", v, 32'h4);
    wr(TxA, 32'd2); wr(TxA, 32'd3); wr(TxA, 32'd4);
    rd(StatusA, v); check("status_full", v, 32'h11);
    wr(TxA, 32'd5);
    rd(DropA, v); check("drop_1", v, 32'd1);
    rd(StatusA, v); check("status_full2", v, 32'h11);

    // Drain: head sequence then empty
    out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), out_data, 32'(i));
      @(negedge CLK);
      #1;
    end
    check("drain_empty", {31'b0, out_valid}, 32'h0);
    rd(StatusA, v); check("status_empty", v, 32'h2);
    out_ready = 1'b0;

    // Clear DROP, then simultaneous push and pop while full
    wr(DropA, 32'h1234);
    rd(DropA, v); check("drop_clear", v, 32'h0);
    wr(TxA, 32'd5); wr(TxA, 32'd6); wr(TxA, 32'd7); wr(TxA, 32'd8);
    out_ready = 1'b1;
    wr(TxA, 32'd9);
    rd(StatusA, v); check("pp_status", v, 32'h11);
    rd(DropA, v);   check("pp_nodrop", v, 32'h0);
    MemWrite = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      check($sformatf("pp_seq_%0d", i), out_data, 32'(i));
      @(negedge CLK);
      #1;
    end
    check("pp_empty", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;

    // Build state for mid-operation reset: 2 entries, DROP=3, err set
    wr(TxA, 32'd1); wr(TxA, 32'd2); wr(TxA, 32'd3); wr(TxA, 32'd4);
    wr(TxA, 32'd7); wr(TxA, 32'd7); wr(TxA, 32'd7);
    out_ready = 1'b1;
    @(negedge CLK); @(negedge CLK);
    out_ready = 1'b0;
    #1;
    rd(StatusA, v); check("pre_status", v, 32'h8);
    rd(DropA, v);   check("pre_drop", v, 32'd3);
    check("pre_head", out_data, 32'd3);
    check("pre_err", {31'b0, err}, 32'h1);

    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    #1;
    check("mr_valid", {31'b0, out_valid}, 32'h0);
    check("mr_err", {31'b0, err}, 32'h0);
    check("mr_out_data", out_data, 32'h0);
    rd(DropA, v);   check("mr_drop", v, 32'h0);
    rd(CycleA, v);  check("mr_cycle0", v, 32'h0);
    rd(32'h10, v);  check("mr_ram", v, 32'h0);
    @(negedge CLK);
    rd(CycleA, v);  check("mr_cycle1", v, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
